// File: rtl/regfile_wr_arbiter.sv
// Two-source writeback arbiter for the single register-file write port.
// Port A has fixed priority; an aging counter forces a grant to port B after MAX_WAIT lost cycles.
module regfile_wr_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_valid,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    output logic              o_a_ready,
    input  logic              i_b_valid,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_b_ready,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_wr_en,
    output logic              o_b_forced
);

    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              a_grant;
    logic              b_grant;
    logic              b_lost;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (!i_rst) begin
            if (state == PRI_A) begin
                a_grant = i_a_valid;
                b_grant = i_b_valid && !i_a_valid;
            end else begin
                b_grant = i_b_valid;
                a_grant = i_a_valid && !i_b_valid;
            end
        end
    end

    assign o_a_ready = a_grant;
    assign o_b_ready = b_grant;
    assign b_lost    = i_b_valid && !b_grant;
    assign sel_addr  = b_grant ? i_b_addr : i_a_addr;
    assign sel_data  = b_grant ? i_b_data : i_a_data;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= PRI_A;
            wait_cnt   <= '0;
            o_b_forced <= 1'b0;
        end else begin
            if (b_lost) begin
                if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            if (state == PRI_A) begin
                if (b_lost && wait_cnt == CNT_LAST) begin
                    state      <= PRI_B;
                    o_b_forced <= 1'b1;
                end
            end else if (b_grant || !i_b_valid) begin
                state      <= PRI_A;
                o_b_forced <= 1'b0;
            end
        end
    end

    // Register x0 is hardwired: a grant to it is consumed but never reaches the file.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_en   <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else begin
            o_wr_en <= 1'b0;
            if ((a_grant || b_grant) && sel_addr != '0) begin
                o_wr_en   <= 1'b1;
                o_rd_addr <= sel_addr;
                o_rd_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single-port writes, x0 filter,
// aging contention pattern and same-address write ordering against a small regfile model.
module tb_regfile_wr_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              b_forced;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] rf [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] last_writes [$];

    regfile_wr_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_a_valid (a_valid),
        .i_a_addr  (a_addr),
        .i_a_data  (a_data),
        .o_a_ready (a_ready),
        .i_b_valid (b_valid),
        .i_b_addr  (b_addr),
        .i_b_data  (b_data),
        .o_b_ready (b_ready),
        .o_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .o_wr_en   (wr_en),
        .o_b_forced(b_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model fed by the write port, with a log of writes to x3.
    always @(posedge clk) begin
        if (wr_en) begin
            rf[rd_addr] <= rd_data;
            if (rd_addr == 5'd3) last_writes.push_back(rd_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 5'd9, 32'hAAAA_0000, 1'b1, 5'd10, 32'hBBBB_0000);
        #3;
        check("rst_a_ready", 64'(a_ready), 64'(1'b0));
        check("rst_b_ready", 64'(b_ready), 64'(1'b0));
        check("rst_wr_en", 64'(wr_en), 64'(1'b0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_forced", 64'(b_forced), 64'(1'b0));
        next_cycle();
        rst = 1'b0;

        // A alone: same-cycle ready, registered write next cycle.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        #1;
        check("a_only_a_ready", 64'(a_ready), 64'(1'b1));
        check("a_only_b_ready", 64'(b_ready), 64'(1'b0));
        next_cycle();
        check("a_only_wr_en", 64'(wr_en), 64'(1'b1));
        check("a_only_rd_addr", 64'(rd_addr), 64'(5));
        check("a_only_rd_data", 64'(rd_data), 64'(32'hDEAD_BEEF));

        // Asynchronous reset while a write is on the port.
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_wr_en", 64'(wr_en), 64'(1'b0));
        check("midrst_rd_addr", 64'(rd_addr), 64'(0));
        check("midrst_rd_data", 64'(rd_data), 64'(0));
        check("midrst_forced", 64'(b_forced), 64'(1'b0));
        next_cycle();
        rst = 1'b0;

        // B alone: granted immediately, aging counter untouched.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55);
        #1;
        check("b_only_b_ready", 64'(b_ready), 64'(1'b1));
        check("b_only_a_ready", 64'(a_ready), 64'(1'b0));
        next_cycle();
        check("b_only_wait_cnt", 64'(dut.wait_cnt), 64'(0));
        check("b_only_wr_en", 64'(wr_en), 64'(1'b1));
        check("b_only_rd_addr", 64'(rd_addr), 64'(7));
        check("b_only_rd_data", 64'(rd_data), 64'(32'h55));

        // Idle cycle: no write, address/data hold.
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        next_cycle();
        check("idle_wr_en", 64'(wr_en), 64'(1'b0));
        check("idle_rd_addr", 64'(rd_addr), 64'(7));
        check("idle_rd_data", 64'(rd_data), 64'(32'h55));

        // x0 destination: accepted, never written.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_b_ready", 64'(b_ready), 64'(1'b1));
        next_cycle();
        check("x0_wr_en", 64'(wr_en), 64'(1'b0));

        // Continuous contention: A wins four cycles, B forced on the fifth.
        for (int k = 1; k <= 10; k++) begin
            logic exp_b;
            exp_b = (k % 5 == 0);
            drive(1'b1, 5'd1, 32'hA000_0000 + 32'(k), 1'b1, 5'd2, 32'hB000_0000 + 32'(k / 5));
            #1;
            check($sformatf("cont%0d_a_ready", k), 64'(a_ready), 64'(!exp_b));
            check($sformatf("cont%0d_b_ready", k), 64'(b_ready), 64'(exp_b));
            check($sformatf("cont%0d_forced", k), 64'(b_forced), 64'(exp_b));
            next_cycle();
            check($sformatf("cont%0d_wr_en", k), 64'(wr_en), 64'(1'b1));
            check($sformatf("cont%0d_rd_addr", k), 64'(rd_addr), exp_b ? 64'(2) : 64'(1));
            check($sformatf("cont%0d_rd_data", k), 64'(rd_data),
                  exp_b ? 64'(32'hB000_0000 + 32'(k / 5)) : 64'(32'hA000_0000 + 32'(k)));
        end

        // Same destination x3: A writes 0x11 until B is forced with 0x22.
        last_writes.delete();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
            next_cycle();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        next_cycle();
        check("same_addr_nwrites", 64'(last_writes.size()), 64'(5));
        if (last_writes.size() == 5) begin
            check("same_addr_4th", 64'(last_writes[3]), 64'(32'h11));
            check("same_addr_5th", 64'(last_writes[4]), 64'(32'h22));
        end
        check("same_addr_rf_x3", 64'(rf[3]), 64'(32'h22));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
